// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
// Optional feature macro: DSP_MAC_SUB_EN (per-term subtract via opmode[7]).
package dsp_seq_pkg;

  localparam logic [7:0] OPM_FIRST   = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC     = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_HOLD    = 8'h08;  // X=0, Z=P (P holds)
  localparam int         OPM_SUB_BIT = 7;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
`ifdef DSP_MAC_SUB_EN
    logic sub;
`endif
  } seq_tag_t;

  // Opmode the slice must register for the term described by a tag.
  function automatic logic [7:0] tag_opmode(input seq_tag_t t);
    logic [7:0] op;
    if (!t.valid) begin
      op = OPM_HOLD;
    end else if (t.first) begin
      op = OPM_FIRST;
    end else begin
      op = OPM_ACC;
    end
`ifdef DSP_MAC_SUB_EN
    if (t.valid && t.sub) begin
      op[OPM_SUB_BIT] = 1'b1;
    end else begin
      op[OPM_SUB_BIT] = 1'b0;
    end
`else
    op[OPM_SUB_BIT] = 1'b0;
`endif
    return op;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand-in and result-out handshakes of the MAC sequencer.
// in_sub is only honoured when DSP_MAC_SUB_EN is defined.
interface dsp_mac_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        in_last;
  logic        in_sub;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic        res_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, in_sub, res_ready,
    output in_ready, res_valid, res_data, res_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, in_sub, res_ready,
    input  in_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/dsp_seq_tag_pipe.sv
// LAT+1-stage tag shift register that follows each slot through the slice.
// Stage LAT-1 steers the opmode, stage LAT+1 lines up with P.
// Tag width depends on DSP_MAC_SUB_EN through seq_tag_t.
module dsp_seq_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  seq_tag_t tag_i,
  output seq_tag_t tap_opm_o,
  output seq_tag_t tap_res_o
);

  // Element s-1 holds the tag that entered s edges ago (stage s).
  seq_tag_t [LAT:0] stage_q;

  // Shift one tag per clock; reset clears all stages to bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[LAT-1:0], tag_i};
    end
  end

  assign tap_opm_o = stage_q[LAT-2];
  assign tap_res_o = stage_q[LAT];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streaming MAC controller for one DSP48A1-style slice: registers operand
// pairs onto A/B, tags every slot, drives opmode from the tag pipeline and
// captures P plus a sticky carry flag once the frame's last term lands.
// Optional feature macro: DSP_MAC_SUB_EN (in_sub sets opmode[7]).
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dsp_mac_sequencer_if.slave         bus,
  output logic [17:0]                dsp_a,
  output logic [17:0]                dsp_b,
  output logic [7:0]                 dsp_opmode,
  input  logic [47:0]                dsp_p,
  input  logic                       dsp_carryout
);

  if (LAT < 3) begin : g_lat_check
    $error("dsp_mac_sequencer: LAT must be >= 3");
  end

  seq_state_e  state_q, state_d;
  logic        first_pend_q, first_pend_d;
  logic [17:0] dsp_a_q, dsp_b_q;
  logic        ovf_q;
  logic [47:0] res_data_q;
  logic        res_ovf_q;

  logic        accept_s;
  logic        carry_s;
  logic        ovf_now_s;
  seq_tag_t    tag_in_s, tap_opm_s, tap_res_s;
  logic        unused_s;

  assign accept_s = bus.in_valid && (state_q == RUN);

  // Build the tag for the slot entering the pipeline this cycle.
  always_comb begin
    tag_in_s       = '0;
    tag_in_s.valid = accept_s;
    tag_in_s.first = accept_s & first_pend_q;
    tag_in_s.last  = accept_s & bus.in_last;
`ifdef DSP_MAC_SUB_EN
    tag_in_s.sub   = accept_s & bus.in_sub;
`endif
  end

  dsp_seq_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_i     (tag_in_s),
    .tap_opm_o (tap_opm_s),
    .tap_res_o (tap_res_s)
  );

`ifdef DSP_MAC_SUB_EN
  assign carry_s  = tap_res_s.valid & ~tap_res_s.sub & dsp_carryout;
  assign unused_s = tap_opm_s.last;
`else
  assign carry_s  = tap_res_s.valid & dsp_carryout;
  assign unused_s = tap_opm_s.last ^ bus.in_sub;
`endif

  // Sticky overflow including the term now leaving the slice; a first term restarts it.
  always_comb begin
    ovf_now_s = ovf_q | carry_s;
    if (tap_res_s.first) begin
      ovf_now_s = carry_s;
    end else begin
      ovf_now_s = ovf_q | carry_s;
    end
  end

  // Frame sequencing: accept terms, wait for the last tag to reach P, hand off the result.
  always_comb begin
    state_d      = state_q;
    first_pend_d = first_pend_q;
    case (state_q)
      RUN: begin
        if (accept_s) begin
          first_pend_d = 1'b0;
          if (bus.in_last) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (tap_res_s.valid && tap_res_s.last) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d      = RUN;
          first_pend_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d      = RUN;
        first_pend_d = 1'b1;
      end
    endcase
  end

  // State and first-term pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      first_pend_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      first_pend_q <= first_pend_d;
    end
  end

  // Operand registers, running overflow and result capture when the last term lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a_q    <= 18'd0;
      dsp_b_q    <= 18'd0;
      ovf_q      <= 1'b0;
      res_data_q <= 48'd0;
      res_ovf_q  <= 1'b0;
    end else begin
      if (accept_s) begin
        dsp_a_q <= bus.in_a;
        dsp_b_q <= bus.in_b;
      end
      if (tap_res_s.valid) begin
        ovf_q <= ovf_now_s;
      end
      if (tap_res_s.valid && tap_res_s.last) begin
        res_data_q <= dsp_p;
        res_ovf_q  <= ovf_now_s;
      end
    end
  end

  assign dsp_a         = dsp_a_q;
  assign dsp_b         = dsp_b_q;
  assign dsp_opmode    = tag_opmode(tap_opm_s);
  assign bus.in_ready  = (state_q == RUN);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

- Streaming multiply-accumulate controller that sequences one DSP48A1-style slice.
- Accepts 18-bit operand pairs over a valid/ready handshake and tags each with first/last/bubble information.
- Drives the slice's A/B operands and 8-bit opmode so that each frame of products is summed in the P register.
- Returns one 48-bit result per frame with a sticky overflow flag; it sits between a coefficient/sample source and the arithmetic slice.

## Interface

Parameters:
- LAT, 3, slice operand-to-P latency in clock edges (A1REG+MREG+PREG); must be ≥3, elaboration error otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts operand pair.
- in_a  in  18  multiplicand (unsigned).
- in_b  in  18  multiplier (unsigned).
- in_last  in  1  final term of frame.
- in_sub  in  1  subtract this term (used only with DSP_MAC_SUB_EN).
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_opmode  out  8  to slice opmode; the slice registers it (opmodeREG=1).
- dsp_p  in  48  slice P.
- dsp_carryout  in  1  slice registered carryout, aligned with P.
- res_valid  out  1  frame result valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  48  accumulated sum.
- res_ovf  out  1  sticky carryout seen during frame.

## Operation

States:
- RUN: in_ready=1.
- DRAIN: in_ready=0; waiting for the last tag to reach the output stage.
- DONE: res_valid=1, in_ready=0.

Transitions:
- RUN→DRAIN on acceptance of a term with in_last=1.
- DRAIN→DONE when the last tag reaches stage LAT+1.
- DONE→RUN on res_valid&&res_ready.

Acceptance and tagging:
- An accept is in_valid&&in_ready at the clock edge.
- On accept, dsp_a/dsp_b register in_a/in_b. Without an accept they hold their value.
- Each cycle a tag {valid, first, last, sub} enters a LAT+1-deep shift pipeline.
- valid=accept.
- first=1 for the first accept after entering RUN.

Opmode, driven from the stage LAT-1 tag:
- first term: 8'h01 (X=M, Z=0).
- later terms: 8'h09 (X=M, Z=P).
- no-accept (bubble) slots: 8'h08 (X=0, Z=P, P holds).
- Bits 6:4 are always 0: no pre-adder, carry-in 0 (CARRYINSEL="opcode5").

Result capture, at stage LAT+1 tag:
- If valid and not sub, ovf_acc |= dsp_carryout.
- If first, ovf_acc restarts from dsp_carryout.
- If last, res_data←dsp_p and res_ovf←final ovf_acc.

Result handshake:
- res_data and res_ovf hold stable while res_valid && !res_ready.
- Only one frame is in flight at a time.

Reset values:
- in_ready=1 after release (state RUN).
- res_valid=0, res_data=0, res_ovf=0.
- dsp_a=0, dsp_b=0, dsp_opmode=8'h08.
- All tags cleared.
- Reset mid-frame abandons the frame; the slice P is not reset. The next frame's first term uses Z=0, so stale P is harmless.

## Timing

- Accept at edge k: dsp_a/dsp_b are valid after k. The slice captures A1 at k+1, M at k+2, P at k+LAT.
- dsp_opmode for that term is driven in the cycle after edge k+LAT-2.
- res_valid rises LAT+1 cycles after the last term's accept edge (4 for LAT=3).
- Throughput is one term per cycle within a frame.
- The inter-frame gap is LAT+1 cycles plus the result handshake.
- in_ready returns high the cycle after the res_valid&&res_ready edge.
- in_last on the first accept gives a single-term frame with opmode 8'h01 only.

## Configuration

DSP_MAC_SUB_EN:
- Defined: in_sub=1 sets opmode[7] for that term, so P=Z-(X+cin). A subtracted first term gives 0-M. Subtract steps do not contribute to res_ovf.
- Undefined: opmode[7] is forced 0, in_sub is ignored, and the sub tag bit is not implemented.

## Structure

- Package dsp_seq_pkg holds:
  - opmode constants OPM_FIRST=8'h01, OPM_ACC=8'h09, OPM_HOLD=8'h08, OPM_SUB_BIT=7;
  - the state enum {RUN, DRAIN, DONE};
  - the tag struct.
- Sub-module dsp_seq_tag_pipe: a parameterised LAT+1-stage tag shift register with taps at stage LAT-1 and stage LAT+1. It has asynchronous active-low reset.

## Test plan

- Frame of 3 contiguous terms (2,3),(4,5),(6,7): opmode sequence 01,09,09 → res_data=68, res_ovf=0, res_valid 4 cycles after the last accept.
- Single term (0x3FFFF,0x3FFFF) with in_last: res_data=0xFFFF80001, in_ready low until the result handshake.
- Same as the first frame but in_valid low for 2 cycles between terms: opmode 08 in the bubble slots, res_data=68.
- Hold res_ready=0 for 10 cycles after res_valid: res_data/res_ovf stable and in_ready=0 throughout. After the handshake, in_ready=1 on the next cycle and the next frame of (1,1) gives 1.
- 4097 terms of (0x3FFFF,0x3FFFF): res_ovf=1. With DSP_MAC_SUB_EN, the frame (10,10) then sub (2,3) gives 94.
- Assert rst_n low mid-frame after 2 accepts: all outputs at their reset values. After release, frame (5,5),(1,1) → 26, res_ovf=0.
